// File: rtl/adc_spi_responder_if.sv
// Serial link bundle between the voltmeter's ADC master and the emulated ADC.
// Signals: sck, mosi (ADC Din), adc_reset (master to ADC); miso (ADC Dout back).
interface adc_spi_responder_if;
  logic sck;
  logic mosi;
  logic adc_reset;
  logic miso;

  modport master (
    output sck,
    output mosi,
    output adc_reset,
    input  miso
  );

  modport slave (
    input  sck,
    input  mosi,
    input  adc_reset,
    output miso
  );
endinterface

// File: rtl/adc_spi_responder.sv
// On-FPGA ADC emulator: oversamples SCK/Din/reset, shifts sample_i out MSB-first
// on miso and captures the command word shifted in on mosi.
// Ports: clk_i, reset (sync, active-high), sample_i/sample_ack_o, link (slave
// modport: sck, mosi, adc_reset in; miso out), cmd_o/cmd_valid_o, frame_err_o,
// busy_o.
// Option: define ADC_SPI_LOOPBACK_EN to echo the previous command instead of
// sample_i.
module adc_spi_responder #(
  parameter int FRAME_BITS   = 16,
  parameter int IDLE_TIMEOUT = 64,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  clk_i,
  input  logic                  reset,
  input  logic [FRAME_BITS-1:0] sample_i,
  output logic                  sample_ack_o,
  adc_spi_responder_if.slave    link,
  output logic [FRAME_BITS-1:0] cmd_o,
  output logic                  cmd_valid_o,
  output logic                  frame_err_o,
  output logic                  busy_o
);

  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam int MSB = FRAME_BITS - 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] arst_sync;
  logic                   sck_d;

  logic sck_s;
  logic mosi_s;
  logic arst_s;
  logic rise;
  logic fall;

  logic [FRAME_BITS-1:0] tx_shift;
  logic [FRAME_BITS-1:0] rx_shift;
  logic [FRAME_BITS-1:0] rx_next;
  logic [FRAME_BITS-1:0] src;
  logic [BW-1:0]         bcnt;
  logic [TW-1:0]         tcnt;
  logic                  miso_q;
  logic                  done;

  assign sck_s   = sck_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign arst_s  = arst_sync[SYNC_STAGES-1];
  assign rise    = sck_s & ~sck_d;
  assign fall    = ~sck_s & sck_d;
  assign rx_next = {rx_shift[MSB-1:0], mosi_s};
  assign link.miso = miso_q;

`ifdef ADC_SPI_LOOPBACK_EN
  assign src = cmd_o;
`else
  assign src = sample_i;
`endif

  always_ff @(posedge clk_i) begin
    if (reset) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      arst_sync <= '0;
      sck_d     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], link.sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], link.mosi};
      arst_sync <= {arst_sync[SYNC_STAGES-2:0], link.adc_reset};
      sck_d     <= sck_s;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state        <= IDLE;
      tx_shift     <= '0;
      rx_shift     <= '0;
      bcnt         <= '0;
      tcnt         <= '0;
      miso_q       <= 1'b0;
      done         <= 1'b0;
      cmd_o        <= '0;
      cmd_valid_o  <= 1'b0;
      sample_ack_o <= 1'b0;
      frame_err_o  <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      sample_ack_o <= 1'b0;
      frame_err_o  <= 1'b0;
      // cmd_o is written one cycle ahead so it is stable under the pulse.
      cmd_valid_o  <= done;
      done         <= 1'b0;
      if (arst_s) begin
        // Datapath reset from the master; cmd_o is kept on purpose.
        state       <= IDLE;
        tx_shift    <= '0;
        rx_shift    <= '0;
        bcnt        <= '0;
        tcnt        <= '0;
        miso_q      <= 1'b0;
        busy_o      <= 1'b0;
        cmd_valid_o <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (rise) begin
              rx_shift     <= {{(FRAME_BITS-1){1'b0}}, mosi_s};
              sample_ack_o <= 1'b1;
              bcnt         <= BW'(1);
              tcnt         <= '0;
              busy_o       <= 1'b1;
              state        <= SHIFT;
            end else begin
              // Keep the first bit on miso ahead of the first rising edge.
              tx_shift <= src;
              miso_q   <= src[MSB];
            end
          end
          SHIFT: begin
            if (tcnt == TW'(IDLE_TIMEOUT)) begin
              frame_err_o <= 1'b1;
              rx_shift    <= '0;
              bcnt        <= '0;
              tcnt        <= '0;
              busy_o      <= 1'b0;
              state       <= IDLE;
            end else if (rise) begin
              rx_shift <= rx_next;
              tcnt     <= '0;
              if (bcnt == BW'(FRAME_BITS - 1)) begin
                cmd_o  <= rx_next;
                done   <= 1'b1;
                bcnt   <= '0;
                busy_o <= 1'b0;
                state  <= IDLE;
              end else begin
                bcnt <= bcnt + BW'(1);
              end
            end else if (fall) begin
              tx_shift <= {tx_shift[MSB-1:0], 1'b0};
              miso_q   <= tx_shift[MSB-1];
              tcnt     <= '0;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Scoreboarded bench for adc_spi_responder: a bit-banged SCK/8 master
// drives frames; a monitor pops expected commands on cmd_valid_o.
`timescale 1ns/1ps
module tb_adc_spi_responder;

  logic        clk_i = 1'b0;
  logic        reset;
  logic [15:0] sample_i;
  logic        sample_ack_o;
  logic [15:0] cmd_o;
  logic        cmd_valid_o;
  logic        frame_err_o;
  logic        busy_o;

  adc_spi_responder_if link();

  adc_spi_responder dut (
    .clk_i        (clk_i),
    .reset        (reset),
    .sample_i     (sample_i),
    .sample_ack_o (sample_ack_o),
    .link         (link.slave),
    .cmd_o        (cmd_o),
    .cmd_valid_o  (cmd_valid_o),
    .frame_err_o  (frame_err_o),
    .busy_o       (busy_o)
  );

  always #240 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int ack_cnt = 0;
  int err_cnt = 0;
  int cmdv_cnt = 0;
  logic [15:0] q[$];
  logic [15:0] last_cmd = 16'h0000;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (!reset) begin
      if (sample_ack_o) ack_cnt++;
      if (frame_err_o) err_cnt++;
      if (cmd_valid_o) begin
        cmdv_cnt++;
        if (q.size() == 0) begin
          chk("cmd_valid_unexpected", {16'h0, cmd_o}, 32'hDEAD);
        end else begin
          chk("cmd_word", {16'h0, cmd_o}, {16'h0, q.pop_front()});
        end
      end
    end
  end

  function automatic logic [15:0] src_model();
`ifdef ADC_SPI_LOOPBACK_EN
    return last_cmd;
`else
    return sample_i;
`endif
  endfunction

  task automatic frame(input logic [15:0] cmd, input int nbits,
                       output logic [15:0] rd);
    rd = 16'h0;
    for (int i = 0; i < nbits; i++) begin
      link.mosi = cmd[15-i];
      repeat (4) @(negedge clk_i);
      rd[15-i] = link.miso;
      link.sck = 1'b1;
      repeat (4) @(negedge clk_i);
      if (i == 4) chk("busy_mid", {31'h0, busy_o}, 32'h1);
      link.sck = 1'b0;
    end
  endtask

  task automatic full(input logic [15:0] smp, input logic [15:0] cmd);
    logic [15:0] rd;
    logic [15:0] exp;
    sample_i = smp;
    exp = src_model();
    q.push_back(cmd);
    frame(cmd, 16, rd);
    chk("miso_word", {16'h0, rd}, {16'h0, exp});
    last_cmd = cmd;
  endtask

  initial begin
    logic [15:0] rd;
    int a0;
    int c0;
    reset = 1'b1;
    sample_i = 16'hA5C3;
    link.sck = 1'b0;
    link.mosi = 1'b0;
    link.adc_reset = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_miso", {31'h0, link.miso}, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_cmd", {16'h0, cmd_o}, 32'h0);
    chk("rst_flags", {29'h0, cmd_valid_o, sample_ack_o, frame_err_o}, 32'h0);
    reset = 1'b0;
    @(negedge clk_i);
    chk("idle_miso", {31'h0, link.miso}, {31'h0, src_model() >> 15});
    repeat (4) @(negedge clk_i);

    a0 = ack_cnt;
    full(16'hA5C3, 16'h8340);
    repeat (4) @(negedge clk_i);
    chk("ack_once", ack_cnt - a0, 1);
    chk("busy_after", {31'h0, busy_o}, 32'h0);

    c0 = cmdv_cnt;
    full(16'h0001, 16'h5A5A);
    full(16'hFFFF, 16'h0F0F);
    repeat (4) @(negedge clk_i);
    chk("b2b_valids", cmdv_cnt - c0, 2);

    sample_i = 16'h3C96;
    frame(16'hBEEF, 7, rd);
    repeat (70) @(negedge clk_i);
    chk("tmo_err", err_cnt, 1);
    chk("tmo_busy", {31'h0, busy_o}, 32'h0);
    chk("tmo_cmd_hold", {16'h0, cmd_o}, {16'h0, last_cmd});
    full(16'h3C96, 16'hC001);
    repeat (4) @(negedge clk_i);

    c0 = cmdv_cnt;
    sample_i = 16'hF00D;
    frame(16'h1111, 9, rd);
    link.adc_reset = 1'b1;
    repeat (6) @(negedge clk_i);
    chk("arst_busy", {31'h0, busy_o}, 32'h0);
    chk("arst_miso", {31'h0, link.miso}, 32'h0);
    chk("arst_cmd_hold", {16'h0, cmd_o}, {16'h0, last_cmd});
    link.adc_reset = 1'b0;
    repeat (6) @(negedge clk_i);
    chk("arst_no_err", err_cnt, 1);
    chk("arst_no_valid", cmdv_cnt - c0, 0);
    chk("arst_rel_miso", {31'h0, link.miso}, {31'h0, src_model() >> 15});
    full(16'hF00D, 16'h7E81);
    repeat (4) @(negedge clk_i);

    full(16'h4242, 16'h1234);
    full(16'h9999, 16'h0000);
    repeat (20) @(negedge clk_i);

    chk("queue_empty", q.size(), 0);
    chk("ack_total", ack_cnt, 9);
    chk("err_total", err_cnt, 1);
    chk("valid_total", cmdv_cnt, 7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
